// File: rtl/ddr3_pg_ring_ctrl_pkg.sv
// Shared definitions for the DDR3 page ring controller.
//   - FSM state encoding (IDLE -> REQ -> REL -> DONE -> IDLE)
//   - page operation codes driven on pg_optype
//   - page index / address / fill counter widths
//   - ring_next(): ring pointer advance with wrap
package ddr3_pg_ring_ctrl_pkg;

  localparam int PAGE_IDX_W = 17;
  localparam int ADDR_W     = 28;
  localparam int FILL_W     = PAGE_IDX_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic PG_OP_WR = 1'b1;
  localparam logic PG_OP_RD = 1'b0;

  // Advance a ring pointer, wrapping from the last page back to the first.
  function automatic logic [PAGE_IDX_W-1:0] ring_next(
    input logic [PAGE_IDX_W-1:0] ptr,
    input logic [PAGE_IDX_W-1:0] first,
    input logic [PAGE_IDX_W-1:0] last
  );
    return (ptr == last) ? first : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/ddr3_pg_ring_ctrl_if.sv
// Page handshake bundle between the ring controller, the DPRAM
// producer/consumer and the page transfer stage.
//   wr_pg_valid/wr_pg_ready : producer offers a full DPRAM page to store
//   rd_pg_valid/rd_pg_ready : consumer asks for the oldest stored page
//   pg_req/pg_optype/pg_req_addr : 4-phase page request to the transfer stage
//   pg_ack                  : transfer-stage acknowledge (asynchronous)
//   wr_done/rd_done         : one-cycle completion pulses
// master = controller view, slave = the surrounding blocks' view.
interface ddr3_pg_ring_ctrl_if;
  import ddr3_pg_ring_ctrl_pkg::*;

  logic              wr_pg_valid;
  logic              wr_pg_ready;
  logic              rd_pg_valid;
  logic              rd_pg_ready;
  logic              pg_req;
  logic              pg_optype;
  logic [ADDR_W-1:0] pg_req_addr;
  logic              pg_ack;
  logic              wr_done;
  logic              rd_done;

  modport master (
    input  wr_pg_valid, rd_pg_valid, pg_ack,
    output wr_pg_ready, rd_pg_ready, pg_req, pg_optype, pg_req_addr,
           wr_done, rd_done
  );

  modport slave (
    output wr_pg_valid, rd_pg_valid, pg_ack,
    input  wr_pg_ready, rd_pg_ready, pg_req, pg_optype, pg_req_addr,
           wr_done, rd_done
  );
endinterface

// File: rtl/ddr3_pg_ring_ctrl_sync.sv
// Two-flop synchronizer cell for a single-bit asynchronous level.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
module ddr3_pg_ring_ctrl_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) stage_reg <= 2'b00;
    else     stage_reg <= {stage_reg[0], d};
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/ddr3_pg_ring_ctrl.sv
// DDR3 page ring controller: stores full DPRAM pages into a ring of DDR3
// pages and fetches them back oldest-first, one page operation at a time,
// through a 4-phase req/ack handshake with the transfer stage.
//   clk, rst   : block clock, synchronous active-high reset
//   calib_done : DDR3 calibration complete (asynchronous, synchronized here)
//   flush      : level request to empty the ring (honoured only in IDLE)
//   bus        : page handshake bundle (master side)
//   fill_cnt   : number of stored pages; full / empty derived from it
module ddr3_pg_ring_ctrl
  import ddr3_pg_ring_ctrl_pkg::*;
#(
  parameter int                    PG_LSB     = 11,
  parameter logic [PAGE_IDX_W-1:0] RING_FIRST = 17'd0,
  parameter logic [PAGE_IDX_W-1:0] RING_LAST  = 17'd131071
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                calib_done,
  input  logic                flush,
  ddr3_pg_ring_ctrl_if.master bus,
  output logic [FILL_W-1:0]   fill_cnt,
  output logic                full,
  output logic                empty
);

  localparam logic [FILL_W-1:0] RING_SIZE =
    FILL_W'(RING_LAST) - FILL_W'(RING_FIRST) + 1'b1;

  logic [1:0]            state_reg;
  logic [PAGE_IDX_W-1:0] wr_ptr_reg;
  logic [PAGE_IDX_W-1:0] rd_ptr_reg;
  logic [FILL_W-1:0]     fill_reg;
  logic                  req_reg;
  logic                  op_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic                  wr_done_reg;
  logic                  rd_done_reg;

  logic [1:0] sync_d;
  logic [1:0] sync_q;
  logic       ack_s;
  logic       cal_s;
  logic       in_idle;
  logic       wr_ready;
  logic       rd_ready;
  logic       wr_fire;
  logic       rd_fire;

  // Bit 0: transfer-stage acknowledge, bit 1: calibration status.
  assign sync_d = {calib_done, bus.pg_ack};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      ddr3_pg_ring_ctrl_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sync_d[gi]),
        .q   (sync_q[gi])
      );
    end
  endgenerate

  assign ack_s = sync_q[0];
  assign cal_s = sync_q[1];

  assign full  = (fill_reg == RING_SIZE);
  assign empty = (fill_reg == '0);

  // Ready only in IDLE; a write offered in the same cycle masks the read so
  // the read simply stays pending until the write has completed.
  assign in_idle  = (state_reg == ST_IDLE);
  assign wr_ready = in_idle & cal_s & ~full & ~flush;
  assign rd_ready = in_idle & cal_s & ~empty & ~flush & ~(bus.wr_pg_valid & wr_ready);
  assign wr_fire  = bus.wr_pg_valid & wr_ready;
  assign rd_fire  = bus.rd_pg_valid & rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      wr_ptr_reg  <= RING_FIRST;
      rd_ptr_reg  <= RING_FIRST;
      fill_reg    <= '0;
      req_reg     <= 1'b0;
      op_reg      <= PG_OP_RD;
      addr_reg    <= '0;
      wr_done_reg <= 1'b0;
      rd_done_reg <= 1'b0;
    end else begin
      wr_done_reg <= 1'b0;
      rd_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Ready is low while flush is high, so no acceptance can collide.
          if (flush) begin
            wr_ptr_reg <= RING_FIRST;
            rd_ptr_reg <= RING_FIRST;
            fill_reg   <= '0;
          end else if (wr_fire) begin
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
            op_reg    <= PG_OP_WR;
            addr_reg  <= ADDR_W'(wr_ptr_reg) << PG_LSB;
          end else if (rd_fire) begin
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
            op_reg    <= PG_OP_RD;
            addr_reg  <= ADDR_W'(rd_ptr_reg) << PG_LSB;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            req_reg   <= 1'b0;
            state_reg <= ST_REL;
          end
        end
        ST_REL: begin
          // Done pulses are registered here so they coincide with DONE.
          if (!ack_s) begin
            state_reg   <= ST_DONE;
            wr_done_reg <= (op_reg == PG_OP_WR);
            rd_done_reg <= (op_reg == PG_OP_RD);
          end
        end
        ST_DONE: begin
          if (op_reg == PG_OP_WR) begin
            wr_ptr_reg <= ring_next(wr_ptr_reg, RING_FIRST, RING_LAST);
            fill_reg   <= fill_reg + 1'b1;
          end else begin
            rd_ptr_reg <= ring_next(rd_ptr_reg, RING_FIRST, RING_LAST);
            fill_reg   <= fill_reg - 1'b1;
          end
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_pg_ready = wr_ready;
  assign bus.rd_pg_ready = rd_ready;
  assign bus.pg_req      = req_reg;
  assign bus.pg_optype   = op_reg;
  assign bus.pg_req_addr = addr_reg;
  assign bus.wr_done     = wr_done_reg;
  assign bus.rd_done     = rd_done_reg;
  assign fill_cnt        = fill_reg;

endmodule

// File: tb/tb_ddr3_pg_ring_ctrl.sv
// Self-checking bench for ddr3_pg_ring_ctrl on a 4-page ring (pages 0..3).
// A behavioural ring model (write index + occupancy) predicts every request
// address and the occupancy outputs; a responder process plays the transfer
// stage and logs each request it sees.
module tb_ddr3_pg_ring_ctrl;
  import ddr3_pg_ring_ctrl_pkg::*;

  localparam int RING_N = 4;
  localparam int LSB    = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        calib_done = 1'b0;
  logic        flush = 1'b0;
  logic [17:0] fill_cnt;
  logic        full;
  logic        empty;

  int checks = 0;
  int passed = 0;
  int ack_delay = 5;
  int stable_err = 0;
  logic [28:0] obs_q[$];
  int m_wr;
  int m_cnt;

  ddr3_pg_ring_ctrl_if bus();

  ddr3_pg_ring_ctrl #(
    .PG_LSB     (LSB),
    .RING_FIRST (17'd0),
    .RING_LAST  (17'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .calib_done (calib_done),
    .flush      (flush),
    .bus        (bus),
    .fill_cnt   (fill_cnt),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Reference model: pages live in a circular buffer of RING_N slots.
  function automatic logic [27:0] exp_addr(input bit is_wr);
    int pg;
    pg = is_wr ? m_wr : (m_wr - m_cnt + RING_N) % RING_N;
    return 28'(pg) << LSB;
  endfunction

  function automatic void model_apply(input bit is_wr);
    if (is_wr) begin
      m_wr = (m_wr + 1) % RING_N;
      m_cnt++;
    end else begin
      m_cnt--;
    end
  endfunction

  // Transfer-stage responder: logs each request, acks after ack_delay cycles,
  // releases ack two cycles after pg_req drops, watches request stability.
  initial begin : responder
    logic [28:0] cur;
    bus.pg_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pg_req === 1'b1 && !rst) begin
        cur = {bus.pg_optype, bus.pg_req_addr};
        obs_q.push_back(cur);
        for (int i = 0; i < ack_delay && !rst; i++) begin
          @(negedge clk);
          if ({bus.pg_optype, bus.pg_req_addr} !== cur) stable_err++;
        end
        bus.pg_ack = 1'b1;
        for (int i = 0; i < 100 && bus.pg_req === 1'b1 && !rst; i++) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          if (!rst && {bus.pg_optype, bus.pg_req_addr} !== cur) stable_err++;
        end
        bus.pg_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  // Offer one page operation, wait for acceptance and completion (bounded).
  task automatic do_op(input bit is_wr, output bit done_ok);
    int n;
    done_ok = 1'b0;
    @(negedge clk);
    if (is_wr) bus.wr_pg_valid = 1'b1;
    else       bus.rd_pg_valid = 1'b1;
    #1;
    n = 0;
    while (((is_wr ? bus.wr_pg_ready : bus.rd_pg_ready) !== 1'b1) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    bus.wr_pg_valid = 1'b0;
    bus.rd_pg_valid = 1'b0;
    n = 0;
    while (((is_wr ? bus.wr_done : bus.rd_done) !== 1'b1) && n < 200) begin
      @(negedge clk); n++;
    end
    done_ok = (n < 200);
    @(negedge clk);
  endtask

  function automatic logic [28:0] pop_obs();
    return (obs_q.size() > 0) ? obs_q.pop_front() : '1;
  endfunction

  task automatic test_reset();
    bus.wr_pg_valid = 1'b0;
    bus.rd_pg_valid = 1'b0;
    rst = 1'b1; calib_done = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.pg_req, bus.pg_optype, bus.wr_done, bus.rd_done, bus.wr_pg_ready,
         bus.rd_pg_ready, full, empty} !== 8'b0000_0001)
      $display("FAIL reset_flags: got %b want 00000001", {bus.pg_req, bus.pg_optype,
               bus.wr_done, bus.rd_done, bus.wr_pg_ready, bus.rd_pg_ready, full, empty});
    else passed++;
    checks++;
    if ({bus.pg_req_addr, fill_cnt} !== 46'd0)
      $display("FAIL reset_addr_fill: got addr %h fill %0d want 0 0", bus.pg_req_addr, fill_cnt);
    else passed++;
    rst = 1'b0; calib_done = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.wr_pg_ready, bus.rd_pg_ready} !== 2'b10)
      $display("FAIL reset_ready_after_cal: got %b want 10", {bus.wr_pg_ready, bus.rd_pg_ready});
    else passed++;
    m_wr = 0; m_cnt = 0;
  endtask

  task automatic test_single_write();
    logic [28:0] got;
    bit ok;
    ack_delay = 5;
    obs_q.delete();
    do_op(1'b1, ok);
    model_apply(1'b1);
    got = pop_obs();
    checks++;
    if (got !== {1'b1, 28'h0} || !ok)
      $display("FAIL single_write_req: got %h done %0d want %h done 1", got, ok, {1'b1, 28'h0});
    else passed++;
    checks++;
    if ({fill_cnt, empty, full} !== {18'd1, 1'b0, 1'b0})
      $display("FAIL single_write_fill: got %0d want 1", fill_cnt);
    else passed++;
  endtask

  task automatic test_write_read();
    bit ops [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [28:0] got, exp;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      ack_delay = 2 + k;
      obs_q.delete();
      exp = {ops[k], exp_addr(ops[k])};
      do_op(ops[k], ok);
      model_apply(ops[k]);
      got = pop_obs();
      checks++;
      if (got !== exp || !ok)
        $display("FAIL write_read_op%0d: got %h done %0d want %h", k, got, ok, exp);
      else passed++;
      if (k == 2) begin
        checks++;
        if (fill_cnt !== 18'd2) $display("FAIL write_read_fill: got %0d want 2", fill_cnt);
        else passed++;
      end
    end
    checks++;
    if (got !== {1'b0, 28'h800}) $display("FAIL next_read_addr: got %h want %h", got, {1'b0, 28'h800});
    else passed++;
  endtask

  task automatic test_priority();
    logic [28:0] exp_w, exp_r;
    int n;
    bit ok;
    ack_delay = 3;
    obs_q.delete();
    exp_w = {1'b1, exp_addr(1'b1)}; model_apply(1'b1);
    exp_r = {1'b0, exp_addr(1'b0)}; model_apply(1'b0);
    @(negedge clk);
    bus.wr_pg_valid = 1'b1; bus.rd_pg_valid = 1'b1;
    #1;
    checks++;
    if ({bus.wr_pg_ready, bus.rd_pg_ready} !== 2'b10)
      $display("FAIL prio_ready: got %b want 10", {bus.wr_pg_ready, bus.rd_pg_ready});
    else passed++;
    @(negedge clk);
    bus.wr_pg_valid = 1'b0;
    n = 0;
    while (bus.rd_pg_ready !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus.rd_pg_valid = 1'b0;
    n = 0;
    while (bus.rd_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    ok = (n < 300);
    @(negedge clk);
    checks++;
    if (obs_q.size() != 2 || !ok)
      $display("FAIL prio_count: got %0d requests done %0d want 2", obs_q.size(), ok);
    else begin
      if (obs_q[0] !== exp_w || obs_q[1] !== exp_r)
        $display("FAIL prio_order: got %h,%h want %h,%h", obs_q[0], obs_q[1], exp_w, exp_r);
      else passed++;
    end
    checks++;
    if (fill_cnt !== 18'd1) $display("FAIL prio_fill: got %0d want 1", fill_cnt);
    else passed++;
  endtask

  task automatic test_flush();
    logic [28:0] got, exp;
    int n;
    bit ok;
    ack_delay = 4;
    do_op(1'b1, ok);
    model_apply(1'b1);
    obs_q.delete();
    exp = {1'b0, exp_addr(1'b0)};
    @(negedge clk);
    bus.rd_pg_valid = 1'b1;
    #1;
    n = 0;
    while (bus.rd_pg_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus.rd_pg_valid = 1'b0;
    checks++;
    if (bus.pg_req !== 1'b1 || fill_cnt !== 18'd2)
      $display("FAIL flush_in_req: got req %b fill %0d want 1 2", bus.pg_req, fill_cnt);
    else passed++;
    flush = 1'b1;
    n = 0;
    while (bus.rd_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    ok = (n < 200);
    repeat (2) @(negedge clk);
    got = pop_obs();
    checks++;
    if (got !== exp || !ok) $display("FAIL flush_transfer: got %h done %0d want %h", got, ok, exp);
    else passed++;
    checks++;
    if ({fill_cnt, empty, bus.wr_pg_ready} !== {18'd0, 1'b1, 1'b0})
      $display("FAIL flush_result: got fill %0d empty %b wr_ready %b want 0 1 0",
               fill_cnt, empty, bus.wr_pg_ready);
    else passed++;
    flush = 1'b0;
    m_wr = 0; m_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [28:0] got, exp;
    bit ok;
    ack_delay = 1;
    for (int k = 0; k < 4; k++) begin
      obs_q.delete();
      exp = {1'b1, exp_addr(1'b1)};
      do_op(1'b1, ok);
      model_apply(1'b1);
      got = pop_obs();
      checks++;
      if (got !== exp || !ok) $display("FAIL wrap_fill_write%0d: got %h want %h", k, got, exp);
      else passed++;
    end
    checks++;
    if ({full, bus.wr_pg_ready, fill_cnt} !== {1'b1, 1'b0, 18'd4})
      $display("FAIL wrap_full: got full %b wr_ready %b fill %0d want 1 0 4",
               full, bus.wr_pg_ready, fill_cnt);
    else passed++;
    obs_q.delete();
    do_op(1'b0, ok);
    model_apply(1'b0);
    do_op(1'b1, ok);
    model_apply(1'b1);
    got = pop_obs();
    got = pop_obs();
    checks++;
    if (got !== {1'b1, 28'h0} || !ok) $display("FAIL wrap_fifth_write: got %h want %h", got, {1'b1, 28'h0});
    else passed++;
  endtask

  task automatic test_calib();
    logic [28:0] got, exp;
    int n, bad;
    bit ok;
    ack_delay = 6;
    obs_q.delete();
    exp = {1'b0, exp_addr(1'b0)};
    @(negedge clk);
    bus.rd_pg_valid = 1'b1;
    #1;
    n = 0;
    while (bus.rd_pg_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus.rd_pg_valid = 1'b0;
    calib_done = 1'b0;
    n = 0;
    while (bus.rd_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    ok = (n < 200);
    @(negedge clk);
    model_apply(1'b0);
    got = pop_obs();
    checks++;
    if (got !== exp || !ok || fill_cnt !== 18'(m_cnt))
      $display("FAIL calib_drop_midway: got %h done %0d fill %0d want %h 1 %0d",
               got, ok, fill_cnt, exp, m_cnt);
    else passed++;
    repeat (3) @(negedge clk);
    bus.wr_pg_valid = 1'b1; bus.rd_pg_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wr_pg_ready !== 1'b0 || bus.rd_pg_ready !== 1'b0 || bus.pg_req !== 1'b0) bad++;
    end
    bus.wr_pg_valid = 1'b0; bus.rd_pg_valid = 1'b0;
    checks++;
    if (bad != 0 || fill_cnt !== 18'(m_cnt))
      $display("FAIL calib_low_block: got %0d bad cycles fill %0d want 0 %0d", bad, fill_cnt, m_cnt);
    else passed++;
    calib_done = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    logic [28:0] got, exp;
    bit is_wr, ok;
    for (int k = 0; k < 40; k++) begin
      if (m_cnt == 0)           is_wr = 1'b1;
      else if (m_cnt == RING_N) is_wr = 1'b0;
      else                      is_wr = ($urandom_range(0, 1) == 1);
      ack_delay = $urandom_range(0, 6);
      obs_q.delete();
      exp = {is_wr, exp_addr(is_wr)};
      do_op(is_wr, ok);
      model_apply(is_wr);
      got = pop_obs();
      checks++;
      if (got !== exp || !ok) $display("FAIL rand_op%0d: got %h done %0d want %h", k, got, ok, exp);
      else passed++;
      checks++;
      if ({fill_cnt, full, empty} !== {18'(m_cnt), m_cnt == RING_N, m_cnt == 0})
        $display("FAIL rand_occ%0d: got fill %0d full %b empty %b want fill %0d",
                 k, fill_cnt, full, empty, m_cnt);
      else passed++;
    end
    checks++;
    if (stable_err != 0) $display("FAIL req_stability: got %0d changes want 0", stable_err);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    ack_delay = 8;
    @(negedge clk);
    if (m_cnt == RING_N) bus.rd_pg_valid = 1'b1;
    else                 bus.wr_pg_valid = 1'b1;
    n = 0;
    while (bus.pg_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bus.wr_pg_valid = 1'b0; bus.rd_pg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (n >= 50 || {bus.pg_req, bus.pg_optype, bus.pg_req_addr, fill_cnt, empty} !==
        {1'b0, 1'b0, 28'h0, 18'd0, 1'b1})
      $display("FAIL reset_mid_handshake: got req %b op %b addr %h fill %0d want 0 0 0 0",
               bus.pg_req, bus.pg_optype, bus.pg_req_addr, fill_cnt);
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    test_reset();
    test_single_write();
    test_write_read();
    test_priority();
    test_flush();
    test_wrap();
    test_calib();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
